// File: rtl/acq_pkg.sv
// Shared types for the acquisition buffer.
package acq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    WAIT = 2'd2,
    POST = 2'd3
  } acq_state_t;

endpackage

// File: rtl/axi4_stream_if.sv
// Minimal AXI4-Stream bundle; the sink runs on the consumer's clock.
interface axi4_stream_if #(
  parameter type DT = logic [16-1:0]
);
  DT    TDATA;
  logic TVALID;
  logic TREADY;
  logic TLAST;

  modport d (input TDATA, TVALID, TLAST, output TREADY);
  modport s (output TDATA, TVALID, TLAST, input TREADY);
endinterface

// File: rtl/sys_bus_if.sv
// Simple CPU system bus: single-cycle request, registered ack.
interface sys_bus_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        wen;
  logic        ren;
  logic [31:0] rdata;
  logic        ack;
  logic        err;

  modport s (input addr, wdata, wen, ren, output rdata, ack, err);
  modport m (output addr, wdata, wen, ren, input rdata, ack, err);
endinterface

// File: rtl/acq.sv
// Acquisition buffer: circular capture RAM with pre/post trigger counting
// and CPU read-back over the system bus.
//
//  state | meaning
//  IDLE  | not capturing, RAM readable, no writes
//  ARM   | capturing, filling pre-trigger history up to cfg_pre samples
//  WAIT  | capturing, history full, waiting for a masked trigger
//  POST  | capturing cfg_pst samples after the trigger sample
module acq
  import acq_pkg::*;
#(
  parameter int unsigned TN  = 1,
  parameter type         DT  = logic [16-1:0],
  parameter int unsigned CWM = 14,
  parameter int unsigned CWL = 32
) (
  input  logic           clk,
  input  logic           rst,
  axi4_stream_if.d       sti,
  input  logic           ctl_rst,
  input  logic           ctl_str,
  input  logic           ctl_stp,
  input  logic [TN-1:0]  trg_i,
  input  logic [TN-1:0]  cfg_trg,
  input  logic [CWL-1:0] cfg_pre,
  input  logic [CWL-1:0] cfg_pst,
  output logic           trg_o,
  output logic           irq_trg,
  output logic           irq_stp,
  output logic           sts_run,
  output logic           sts_trg,
  output logic [CWL-1:0] sts_pre,
  output logic [CWL-1:0] sts_pst,
  output logic [CWM-1:0] sts_ptr,
  sys_bus_if.s           bus
);

  localparam int unsigned DEPTH = 2**CWM;

  acq_state_t     state_q, state_d;
  logic [CWM-1:0] wptr_q, wptr_d;
  logic [CWL-1:0] pre_q, pre_d;
  logic [CWL-1:0] pst_q, pst_d;
  logic [CWM-1:0] ptr_q, ptr_d;
  logic           trg_seen_q, trg_seen_d;
  logic           trg_o_q;
  logic           irq_stp_q;
  logic           ack_q;
  DT              rdata_q;
  DT              ram [DEPTH];

  logic beat, running, trg_any, trg_acc, pre_cnt, post_full, post_last, wr_en, stop_evt;
  logic unused_bits;

  assign beat      = sti.TVALID;
  assign running   = (state_q != IDLE);
  assign trg_any   = |(trg_i & cfg_trg);
  // Any control pulse in the same cycle outranks the trigger.
  assign trg_acc   = (state_q == WAIT) && trg_any && !ctl_rst && !ctl_stp && !ctl_str;
  assign pre_cnt   = beat && ((state_q == ARM) || (state_q == WAIT)) && (pre_q < cfg_pre);
  assign post_full = (state_q == POST) && (pst_q == cfg_pst);
  // Leave POST on the beat that completes the count, so exactly cfg_pst samples follow the trigger sample.
  assign post_last = post_full || ((state_q == POST) && beat && ((pst_q + CWL'(1)) == cfg_pst));
  assign wr_en     = running && beat && !post_full;

  // Next-state and counter update, ordered by control priority.
  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    pre_d      = pre_q;
    pst_d      = pst_q;
    ptr_d      = ptr_q;
    trg_seen_d = trg_seen_q;
    stop_evt   = 1'b0;
    if (wr_en) wptr_d = wptr_q + CWM'(1);
    if (ctl_rst) begin
      state_d    = IDLE;
      wptr_d     = '0;
      pre_d      = '0;
      pst_d      = '0;
      ptr_d      = '0;
      trg_seen_d = 1'b0;
    end else if (ctl_stp && running) begin
      state_d  = IDLE;
      stop_evt = 1'b1;
    end else if (ctl_str) begin
      state_d    = ARM;
      pre_d      = '0;
      pst_d      = '0;
      trg_seen_d = 1'b0;
    end else begin
      if (pre_cnt) pre_d = pre_q + CWL'(1);
      case (state_q)
        ARM: if (pre_q == cfg_pre) state_d = WAIT;
        WAIT: if (trg_acc) begin
          state_d    = POST;
          trg_seen_d = 1'b1;
          ptr_d      = wptr_q;
          pst_d      = '0;
        end
        POST: begin
          if (!post_full && beat) pst_d = pst_q + CWL'(1);
          if (post_last) begin
            state_d  = IDLE;
            stop_evt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Control and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      pre_q      <= '0;
      pst_q      <= '0;
      ptr_q      <= '0;
      trg_seen_q <= 1'b0;
      trg_o_q    <= 1'b0;
      irq_stp_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      pre_q      <= pre_d;
      pst_q      <= pst_d;
      ptr_q      <= ptr_d;
      trg_seen_q <= trg_seen_d;
      trg_o_q    <= trg_acc;
      irq_stp_q  <= stop_evt;
    end
  end

  // Stream write port of the capture RAM.
  always_ff @(posedge clk) begin
    if (wr_en) ram[wptr_q] <= sti.TDATA;
  end

  // Bus read port; a same-cycle write is not visible until the next read.
  always_ff @(posedge clk) begin
    if (bus.ren) rdata_q <= ram[bus.addr[CWM-1:0]];
  end

  // Every bus request is acknowledged one cycle later; writes are discarded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ack_q <= 1'b0;
    else     ack_q <= bus.ren | bus.wen;
  end

  // Zero-extend the RAM word onto the bus data width.
  always_comb begin
    bus.rdata = '0;
    bus.rdata[$bits(DT)-1:0] = rdata_q;
  end

  assign bus.ack    = ack_q;
  assign bus.err    = 1'b0;
  assign sti.TREADY = 1'b1;

  assign trg_o   = trg_o_q;
  assign irq_trg = trg_acc;
  assign irq_stp = irq_stp_q;
  assign sts_run = running;
  assign sts_trg = trg_seen_q;
  assign sts_pre = pre_q;
  assign sts_pst = pst_q;
  assign sts_ptr = ptr_q;

  assign unused_bits = ^{sti.TLAST, bus.wdata, bus.addr[31:CWM]};

endmodule

// File: tb/tb_acq.sv
// Bench for acq: cycle-level reference model plus directed capture scenarios.
module tb_acq;

  localparam int DEPTH = 16384;
  localparam int P_IDLE = 0, P_ARM = 1, P_WAIT = 2, P_POST = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ctl_rst = 1'b0, ctl_str = 1'b0, ctl_stp = 1'b0;
  logic [0:0]  trg_i = 1'b0, cfg_trg = 1'b1;
  logic [31:0] cfg_pre = '0, cfg_pst = '0;
  logic        trg_o, irq_trg, irq_stp, sts_run, sts_trg;
  logic [31:0] sts_pre, sts_pst;
  logic [13:0] sts_ptr;

  axi4_stream_if #(.DT(logic [15:0])) sti ();
  sys_bus_if bus ();

  acq dut (
    .clk(clk), .rst(rst), .sti(sti),
    .ctl_rst(ctl_rst), .ctl_str(ctl_str), .ctl_stp(ctl_stp),
    .trg_i(trg_i), .cfg_trg(cfg_trg), .cfg_pre(cfg_pre), .cfg_pst(cfg_pst),
    .trg_o(trg_o), .irq_trg(irq_trg), .irq_stp(irq_stp),
    .sts_run(sts_run), .sts_trg(sts_trg), .sts_pre(sts_pre),
    .sts_pst(sts_pst), .sts_ptr(sts_ptr), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_errors = 0;
  int cyc = 0, ramp = 0, t_trg = -1, t_stp = -1;
  bit rand_valid = 0, valid_on = 1, rand_bus = 0, rand_trg = 0;

  // reference model
  int          m_ph = P_IDLE, m_wptr = 0, m_ptr = 0;
  longint      m_pre = 0, m_pst = 0;
  bit          m_trg = 0, m_trg_o = 0, m_irq_stp = 0, m_ack = 0, m_rd_valid = 0, m_rd_known = 0;
  logic [15:0] m_rdata = '0;
  logic [15:0] m_mem [DEPTH];
  bit          m_wr  [DEPTH];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit m_accept();
    return (m_ph == P_WAIT) && ((trg_i & cfg_trg) != 0) && !ctl_rst && !ctl_stp && !ctl_str;
  endfunction

  task automatic m_step();
    bit acc, busy, wr, v, done;
    int a, w_old;
    v     = sti.TVALID;
    acc   = m_accept();
    busy  = (m_ph != P_IDLE);
    wr    = busy && v && !((m_ph == P_POST) && (m_pst == longint'(cfg_pst)));
    w_old = m_wptr;
    done  = 0;
    m_rd_valid = bus.ren;
    if (bus.ren) begin
      a = int'(bus.addr % DEPTH);
      m_rd_known = m_wr[a];
      m_rdata = m_mem[a];
    end
    m_ack     = bus.ren | bus.wen;
    m_trg_o   = acc;
    m_irq_stp = 0;
    if (wr) begin
      m_mem[m_wptr] = sti.TDATA;
      m_wr[m_wptr]  = 1;
      m_wptr        = (m_wptr + 1) % DEPTH;
    end
    if (ctl_rst) begin
      m_ph = P_IDLE; m_wptr = 0; m_pre = 0; m_pst = 0; m_ptr = 0; m_trg = 0;
    end else if (ctl_stp && busy) begin
      m_ph = P_IDLE; m_irq_stp = 1;
    end else if (ctl_str) begin
      m_ph = P_ARM; m_pre = 0; m_pst = 0; m_trg = 0;
    end else begin
      if (m_ph == P_ARM) begin
        if (m_pre == longint'(cfg_pre)) m_ph = P_WAIT;
        else if (v) m_pre++;
      end else if (m_ph == P_WAIT) begin
        if (v && m_pre < longint'(cfg_pre)) m_pre++;
        if (acc) begin
          m_ph = P_POST; m_trg = 1; m_ptr = w_old; m_pst = 0;
        end
      end else if (m_ph == P_POST) begin
        if (m_pst == longint'(cfg_pst)) done = 1;
        else if (v) begin
          m_pst++;
          if (m_pst == longint'(cfg_pst)) done = 1;
        end
        if (done) begin
          m_ph = P_IDLE; m_irq_stp = 1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    if (irq_trg === 1'b1) t_trg = cyc;
    if (irq_stp === 1'b1) t_stp = cyc;
    chk("run", sts_run, m_ph != P_IDLE);
    chk("sts_trg", sts_trg, m_trg);
    chk("sts_pre", sts_pre, 64'(m_pre));
    chk("sts_pst", sts_pst, 64'(m_pst));
    chk("sts_ptr", sts_ptr, 64'(m_ptr));
    chk("irq_trg", irq_trg, m_accept());
    chk("trg_o", trg_o, m_trg_o);
    chk("irq_stp", irq_stp, m_irq_stp);
    chk("ack", bus.ack, m_ack);
    chk("tready", sti.TREADY, 1'b1);
    chk("err", bus.err, 1'b0);
    if (m_rd_valid && m_rd_known) chk("rdata", bus.rdata, {16'h0, m_rdata});
  endtask

  task automatic cycle();
    sti.TVALID = valid_on && (rand_valid ? ($urandom_range(0, 1) == 1) : 1'b1);
    sti.TDATA  = 16'(ramp);
    sti.TLAST  = ($urandom_range(0, 1) == 1);
    if (rand_trg) trg_i = ($urandom_range(0, 7) == 0);
    if (rand_bus) begin
      bus.ren   = ($urandom_range(0, 3) == 0);
      bus.wen   = ($urandom_range(0, 7) == 0);
      bus.addr  = $urandom;
      bus.wdata = $urandom;
    end
    @(negedge clk);
    check_outputs();
    m_step();
    if (sti.TVALID) ramp++;
    @(posedge clk);
    #1;
    ctl_rst = 0; ctl_str = 0; ctl_stp = 0;
    bus.ren = 0; bus.wen = 0;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (sts_run && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, sts_run, 1'b0);
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    bus.ren  = 1;
    bus.addr = 32'(a);
    cycle();
    d = bus.rdata;
  endtask

  initial begin
    logic [31:0] d;
    int w0, nrun;
    sti.TVALID = 0; sti.TDATA = '0; sti.TLAST = 0;
    bus.ren = 0; bus.wen = 0; bus.addr = '0; bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_run", sts_run, 1'b0);
    chk("rst_trg", sts_trg, 1'b0);
    chk("rst_pre", sts_pre, 0);
    chk("rst_pst", sts_pst, 0);
    chk("rst_ptr", sts_ptr, 0);
    chk("rst_trg_o", trg_o, 1'b0);
    chk("rst_irq_stp", irq_stp, 1'b0);
    chk("rst_ack", bus.ack, 1'b0);
    run(3);

    // ramp capture, trigger on sample 100
    cfg_pre = 8; cfg_pst = 16; cfg_trg = 1; ramp = 0;
    ctl_str = 1; cycle();
    t_trg = -1; t_stp = -1;
    for (int i = 0; i < 300 && sts_run; i++) begin
      trg_i = (ramp == 100);
      cycle();
    end
    trg_i = 0;
    chk("ramp_timeout", sts_run, 1'b0);
    cycle();
    chk("ramp_stp_delay", t_stp - t_trg, 17);
    for (int i = 0; i < 24; i++) begin
      bus_read((m_ptr - 8 + i + DEPTH) % DEPTH, d);
      chk("ramp_window", d, 92 + i);
    end

    // trigger during ARM is ignored, masked trigger ignored, WAIT trigger accepted
    cfg_pre = 20; cfg_pst = 5;
    ctl_str = 1; cycle();
    run(3);
    trg_i = 1; cycle(); trg_i = 0;
    run(2);
    chk("arm_trg_ignored", sts_trg, 1'b0);
    run(25);
    cfg_trg = 0; trg_i = 1; cycle(); trg_i = 0; cfg_trg = 1;
    chk("masked_trg_ignored", sts_trg, 1'b0);
    trg_i = 1; cycle(); trg_i = 0;
    chk("wait_trg_accepted", sts_trg, 1'b1);
    chk("wait_trg_o", trg_o, 1'b1);
    wait_done("arm_ign", 50);
    run(2);

    // random beats and triggers, random bus traffic
    rand_valid = 1; rand_bus = 1;
    for (int r = 0; r < 3; r++) begin
      cfg_pre = 5; cfg_pst = 10;
      ctl_str = 1; cycle();
      rand_trg = 1;
      wait_done("rnd", 600);
      rand_trg = 0; trg_i = 0;
      chk("rnd_post_beats", sts_pst, 10);
      run(3);
    end
    rand_valid = 0; rand_bus = 0;

    // zero-length windows with trigger held high, no beats
    valid_on = 0; cfg_pre = 0; cfg_pst = 0; trg_i = 1;
    w0 = m_wptr;
    ctl_str = 1; cycle();
    nrun = 0;
    for (int i = 0; i < 6; i++) begin
      if (sts_run) nrun++;
      cycle();
    end
    trg_i = 0; valid_on = 1;
    chk("zero_run_cycles", nrun, 3);
    chk("zero_ptr", sts_ptr, 64'(w0));
    chk("zero_trg", sts_trg, 1'b1);

    // stop in the middle of POST
    cfg_pre = 4; cfg_pst = 50;
    ctl_str = 1; cycle();
    run(8);
    trg_i = 1; cycle(); trg_i = 0;
    run(10);
    ctl_stp = 1; cycle();
    chk("stp_irq", irq_stp, 1'b1);
    chk("stp_run", sts_run, 1'b0);
    chk("stp_pst_held", sts_pst, 10);
    cycle();
    chk("stp_irq_one_cycle", irq_stp, 1'b0);

    // synchronous clear in the middle of POST
    ctl_str = 1; cycle();
    run(8);
    trg_i = 1; cycle(); trg_i = 0;
    run(5);
    ctl_rst = 1; cycle();
    chk("crst_run", sts_run, 1'b0);
    chk("crst_pre", sts_pre, 0);
    chk("crst_pst", sts_pst, 0);
    chk("crst_ptr", sts_ptr, 0);
    chk("crst_trg", sts_trg, 1'b0);
    chk("crst_irq", irq_stp, 1'b0);
    cycle();
    chk("crst_irq_late", irq_stp, 1'b0);

    // pre-trigger longer than the RAM; trigger held from the start
    cfg_pre = DEPTH + 5; cfg_pst = 4; trg_i = 1; rand_bus = 1;
    ctl_str = 1; cycle();
    wait_done("wrap", 17000);
    trg_i = 0; rand_bus = 0;
    chk("wrap_trg", sts_trg, 1'b1);
    chk("wrap_pre_sat", sts_pre, DEPTH + 5);
    for (int i = 0; i < 16; i++) begin
      int a;
      a = $urandom_range(0, DEPTH - 1);
      bus_read(a, d);
      chk("wrap_ram", d, {16'h0, m_mem[a]});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
